// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared op encodings, FSM states and lane constants for the LSU.
// Op encoding is {store, unsigned, size[1:0]} so the datapath can decode by bit.
package load_store_unit_pkg;
    localparam int LSU_OP_BITS = 4;
    localparam int BYTE_LANES  = 4;

    typedef enum logic [LSU_OP_BITS-1:0] {
        OP_LB  = 4'h0,
        OP_LH  = 4'h1,
        OP_LW  = 4'h2,
        OP_LBU = 4'h4,
        OP_LHU = 4'h5,
        OP_SB  = 4'h8,
        OP_SH  = 4'h9,
        OP_SW  = 4'hA
    } lsu_op_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores, load extract/extend and misalignment detection.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  lsu_op_t                   op,
    input  logic [1:0]                off,
    input  logic [8*BYTE_LANES-1:0]   wdata,
    input  logic [8*BYTE_LANES-1:0]   rdata,
    output logic [BYTE_LANES-1:0]     be,
    output logic [8*BYTE_LANES-1:0]   wdata_lane,
    output logic [8*BYTE_LANES-1:0]   ld_data,
    output logic                      misalign
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        is_b, is_h, sx;

    always_comb begin
        is_b       = op[1:0] == 2'd0;
        is_h       = op[1:0] == 2'd1;
        sx         = !op[2];
        b          = rdata[8*off +: 8];
        h          = off[1] ? rdata[31:16] : rdata[15:0];
        misalign   = (is_h && off[0]) || (op[1:0] == 2'd2 && off != 2'd0);
        be         = !op[3] ? 4'b1111 : is_b ? 4'b0001 << off : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_lane = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
        ld_data    = is_b ? {{24{b[7] & sx}}, b} : is_h ? {{16{h[15] & sx}}, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store stage between EX and writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            store_done,
    output logic            misalign_exc,
    output logic [XLEN-1:0] exc_addr
);
    lsu_state_t      state_q, state_d;
    lsu_op_t         op_q, op_d, a_op;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d, exc_addr_q, exc_addr_d;
    logic [4:0]      rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic            kill_q, kill_d, store_done_q, store_done_d, wb_valid_q, wb_valid_d, mis_q, mis_d;
    logic            idle, misalign;
    logic [1:0]      a_off;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_lane, ld_data;

    // In IDLE the aligner checks the incoming op; otherwise it works on the registered request.
    assign idle  = state_q == IDLE;
    assign a_op  = idle ? lsu_op_t'(req_op) : op_q;
    assign a_off = idle ? req_addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .op         (a_op),
        .off        (a_off),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .be         (be),
        .wdata_lane (wdata_lane),
        .ld_data    (ld_data),
        .misalign   (misalign)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        kill_d       = kill_q;
        store_done_d = 1'b0;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        mis_d        = 1'b0;
        exc_addr_d   = exc_addr_q;
        case (state_q)
            IDLE: if (req_valid && !flush) begin
                if (misalign) begin
                    mis_d      = 1'b1;
                    exc_addr_d = req_addr;
                end else begin
                    state_d = REQ;
                    op_d    = lsu_op_t'(req_op);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    kill_d  = 1'b0;
                end
            end
            REQ: if (mem_gnt) begin
                // A granted store is committed even if flushed in the same cycle.
                state_d      = op_q[3] ? IDLE : WAIT;
                store_done_d = op_q[3];
                kill_d       = flush;
            end else if (flush) begin
                state_d = IDLE;
            end
            WAIT: begin
                kill_d = kill_q || flush;
                if (mem_rvalid) begin
                    state_d    = IDLE;
                    wb_valid_d = !(kill_q || flush);
                    wb_rd_d    = rd_q;
                    wb_data_d  = ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= OP_LB;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            kill_q       <= 1'b0;
            store_done_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            mis_q        <= 1'b0;
            exc_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            kill_q       <= kill_d;
            store_done_q <= store_done_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            mis_q        <= mis_d;
            exc_addr_q   <= exc_addr_d;
        end
    end

    assign req_ready    = idle;
    assign mem_req      = state_q == REQ;
    assign mem_we       = mem_req && op_q[3];
    assign mem_addr     = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_be       = mem_req ? be : 4'b0000;
    assign mem_wdata    = mem_we ? wdata_lane : '0;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign store_done   = store_done_q;
    assign misalign_exc = mis_q;
    assign exc_addr     = exc_addr_q;
endmodule
